// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic initiator.
//   - Wishbone bus widths (address, data, byte-select)
//   - default timeout depth and counter width
//   - FSM state encoding
//   - latched command and response record layouts
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam int WB_TIMEOUT_CYCLES = 255;
  localparam int WB_TIMEOUT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
  } wb_cmd_t;

  typedef struct packed {
    logic [WB_DAT_W-1:0] rdata;
    logic                err;
  } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog for the initiator.
//   clk_i/rst_i : clock, synchronous active-high reset
//   clr_i       : restart the count at zero (takes priority over en_i)
//   en_i        : count one bus cycle
//   expire_o    : high during the TIMEOUT_CYCLES-th enabled cycle since clear
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH  = WB_TIMEOUT_WIDTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Count starts at 0 in the first bus cycle, so matching N-1 flags the Nth.
  assign expire_o = en_i && (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transaction initiator.
// A command accepted on the cmd_* handshake becomes one Wishbone cycle; the
// result (read data or timeout error) is returned on the rsp_* handshake.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   cmd_valid/ready     : command handshake; cmd_we/addr/wdata/sel payload
//   rsp_valid/ready     : response handshake; rsp_rdata, rsp_err payload
//   wbm_*               : Wishbone classic master port
// All wbm_* and rsp_* outputs come straight from flops.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH  = WB_TIMEOUT_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_addr_i,
  input  logic [WB_DAT_W-1:0] cmd_wdata_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  wb_state_e state_q, state_d;
  wb_cmd_t   cmd_q, cmd_d;
  wb_rsp_t   rsp_q, rsp_d;
  logic      cyc_q, cyc_d;
  logic      rsp_valid_q, rsp_valid_d;
  logic      tmo_clr, tmo_en, tmo_expire;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d   = '{we: cmd_we_i, adr: cmd_addr_i, dat: cmd_wdata_i, sel: cmd_sel_i};
          tmo_clr = 1'b1;
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        tmo_en = 1'b1;
        // Ack is checked first so a last-cycle ack still completes cleanly.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_d.rdata = cmd_q.we ? '0 : wbm_dat_i;
          rsp_d.err   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (tmo_expire) begin
          cyc_d       = 1'b0;
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Gated by rst_i so no command is offered while reset is held.
  assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = cmd_q.we;
  assign wbm_adr_o   = cmd_q.adr;
  assign wbm_dat_o   = cmd_q.dat;
  assign wbm_sel_o   = cmd_q.sel;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_wb_initiator.sv
module tb_wb_initiator;

  localparam int T = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  wb_initiator #(.TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction. ack_at = BUS cycle (1-based) on which the responder
  // acks, 0 = never. hold = cycles rsp_ready stays low once the response is up.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                     input logic [3:0] sel, input int ack_at, input logic [31:0] rd,
                     input int hold);
    exp_t        e;
    int          n;
    int          exp_cyc;
    logic        tmo;
    logic [31:0] first_rd;
    logic        first_err;
    tmo     = (ack_at == 0) || (ack_at > T);
    exp_cyc = tmo ? T : ack_at;
    e.err   = tmo;
    e.rdata = (tmo || we) ? 32'h0 : rd;
    chk("idle_ready", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = adr; cmd_wdata_i = wd; cmd_sel_i = sel;
    sb.push_back(e);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_we_i = ~we; cmd_addr_i = 32'hFFFF_0000; cmd_wdata_i = 32'h1111_2222; cmd_sel_i = 4'h0;
    chk("issue_latency", 32'(wbm_cyc_o), 32'd1);
    n = 0;
    while (wbm_cyc_o === 1'b1 && n < 20) begin
      n++;
      chk("bus_stb", 32'(wbm_stb_o), 32'd1);
      chk("bus_we", 32'(wbm_we_o), 32'(we));
      chk("bus_adr", wbm_adr_o, adr);
      chk("bus_dat", wbm_dat_o, wd);
      chk("bus_sel", 32'(wbm_sel_o), 32'(sel));
      chk("bus_cmd_ready", 32'(cmd_ready_o), 32'd0);
      chk("bus_rsp_valid", 32'(rsp_valid_o), 32'd0);
      if (n == ack_at) begin wbm_ack_i = 1'b1; wbm_dat_i = rd; end
      else begin wbm_ack_i = 1'b0; wbm_dat_i = 32'hA5A5_0000 | 32'(n); end
      @(negedge clk_i);
    end
    wbm_ack_i = 1'b0;
    chk("cyc_dropped", 32'(wbm_cyc_o), 32'd0);
    chk("stb_dropped", 32'(wbm_stb_o), 32'd0);
    chk("cyc_cycles", 32'(n), 32'(exp_cyc));
    first_rd  = rsp_rdata_o;
    first_err = rsp_err_o;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("hold_rdata", rsp_rdata_o, first_rd);
      chk("hold_err", 32'(rsp_err_o), 32'(first_err));
      chk("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
      chk("hold_no_accept", 32'(wbm_cyc_o), 32'd0);
      cmd_valid_i = 1'b1; cmd_addr_i = 32'hBAD0_0000 | 32'(i);
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h5555_5555;
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    wbm_ack_i   = 1'b0;
    chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata_o, e.rdata);
      chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("post_cyc", 32'(wbm_cyc_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0;
    cmd_wdata_i = '0; cmd_sel_i = '0; rsp_ready_i = 1'b0;
    wbm_ack_i = 1'b0; wbm_dat_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_sel", 32'(wbm_sel_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Stray ack while idle must not start or complete anything.
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h7777_7777;
    repeat (3) begin
      @(negedge clk_i);
      chk("idle_ack_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("idle_ack_rsp", 32'(rsp_valid_o), 32'd0);
    end
    wbm_ack_i = 1'b0;

    txn(1'b1, 32'h3002_0000, 32'h0000_0100, 4'hF, 2, 32'hFFFF_FFFF, 0);
    txn(1'b0, 32'h3002_0000, 32'h0,         4'hF, 2, 32'hDEAD_BEEF, 0);
    txn(1'b0, 32'h3002_0004, 32'h0,         4'h3, 0, 32'h0BAD_0BAD, 0);
    txn(1'b0, 32'h3002_0008, 32'h0,         4'hC, 4, 32'h1234_5678, 0);
    txn(1'b0, 32'h3002_000C, 32'h0,         4'h1, 1, 32'hCAFE_F00D, 5);
    txn(1'b1, 32'h4000_0010, 32'hAAAA_5555, 4'h6, 0, 32'h0,         2);

    // Reset during the second BUS cycle drops the transaction silently.
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h5000_0000; cmd_sel_i = 4'hF;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("rstbus_c1", 32'(wbm_cyc_o), 32'd1);
    @(negedge clk_i);
    chk("rstbus_c2", 32'(wbm_cyc_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rstbus_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rstbus_stb", 32'(wbm_stb_o), 32'd0);
    chk("rstbus_adr", wbm_adr_o, 32'd0);
    chk("rstbus_rsp", 32'(rsp_valid_o), 32'd0);
    chk("rstbus_ready", 32'(cmd_ready_o), 32'd0);
    rst_i = 1'b0;
    repeat (2 * T) begin
      @(negedge clk_i);
      chk("rstbus_quiet_rsp", 32'(rsp_valid_o), 32'd0);
      chk("rstbus_quiet_cyc", 32'(wbm_cyc_o), 32'd0);
    end

    txn(1'b0, 32'h3002_0000, 32'h0, 4'hF, 3, 32'h600D_600D, 1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
